// File: rtl/fetch_pc_unit.sv
// Multicycle MIPS fetch/PC datapath: PC, IR, MDR and ALU-out registers,
// next-PC selection, memory address mux and IR field slicing.
module fetch_pc_unit #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_PC  = '0,
    parameter int                 CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 PC_Write,
    input  logic                 Branch,
    input  logic                 PC_Src,
    input  logic                 PC_J,
    input  logic                 IR_Write,
    input  logic                 IorD,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_zero,
    input  logic [WIDTH-1:0]     rd_data,
    output logic [WIDTH-1:0]     mem_addr,
    output logic [WIDTH-1:0]     pc,
    output logic [WIDTH-1:0]     instr,
    output logic [5:0]           Op,
    output logic [5:0]           Funct,
    output logic [4:0]           rs,
    output logic [4:0]           rt,
    output logic [4:0]           rd,
    output logic [15:0]          imm,
    output logic [WIDTH-1:0]     alu_out,
    output logic [WIDTH-1:0]     mdr,
    output logic [CNT_WIDTH-1:0] fetch_count,
    output logic                 pc_misaligned
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]     pc_q, pc_d;
    logic [WIDTH-1:0]     instr_q, instr_d;
    logic [WIDTH-1:0]     alu_out_q, alu_out_d;
    logic [WIDTH-1:0]     mdr_q, mdr_d;
    logic [CNT_WIDTH-1:0] fetch_count_q, fetch_count_d;
    logic                 pc_misaligned_q, pc_misaligned_d;
    logic [WIDTH-1:0]     next_pc;
    logic [WIDTH-1:0]     jump_target;
    logic                 pc_en;

    assign pc_en = PC_Write | (Branch & alu_zero);

    // Jump target keeps the upper PC nibble of the already-incremented PC
    assign jump_target = {pc_q[WIDTH-1:28], instr_q[25:0], 2'b00};

    always_comb begin
        next_pc = alu_result;
        if (PC_Src) begin
            next_pc = PC_J ? alu_out_q : jump_target;
        end
    end

    always_comb begin
        pc_d            = pc_q;
        instr_d         = instr_q;
        fetch_count_d   = fetch_count_q;
        pc_misaligned_d = pc_misaligned_q;
        alu_out_d       = alu_result;
        mdr_d           = rd_data;
        if (pc_en) begin
            pc_d = next_pc;
            if (next_pc[1:0] != 2'b00) begin
                pc_misaligned_d = 1'b1;
            end
        end
        if (IR_Write) begin
            instr_d       = rd_data;
            fetch_count_d = fetch_count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q            <= RESET_PC;
            instr_q         <= '0;
            alu_out_q       <= '0;
            mdr_q           <= '0;
            fetch_count_q   <= '0;
            pc_misaligned_q <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            instr_q         <= instr_d;
            alu_out_q       <= alu_out_d;
            mdr_q           <= mdr_d;
            fetch_count_q   <= fetch_count_d;
            pc_misaligned_q <= pc_misaligned_d;
        end
    end

    assign mem_addr      = IorD ? alu_out_q : pc_q;
    assign pc            = pc_q;
    assign instr         = instr_q;
    assign alu_out       = alu_out_q;
    assign mdr           = mdr_q;
    assign fetch_count   = fetch_count_q;
    assign pc_misaligned = pc_misaligned_q;

    assign Op    = instr_q[31:26];
    assign Funct = instr_q[5:0];
    assign rs    = instr_q[25:21];
    assign rt    = instr_q[20:16];
    assign rd    = instr_q[15:11];
    assign imm   = instr_q[15:0];

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed-vector bench for fetch_pc_unit (counter built 4 bits wide
// so that wrap-around is reachable).
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst;
    logic        PC_Write;
    logic        Branch;
    logic        PC_Src;
    logic        PC_J;
    logic        IR_Write;
    logic        IorD;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [31:0] rd_data;
    logic [31:0] mem_addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [31:0] alu_out;
    logic [31:0] mdr;
    logic [3:0]  fetch_count;
    logic        pc_misaligned;

    int errors = 0;
    int checks = 0;

    fetch_pc_unit #(
        .WIDTH     (32),
        .RESET_PC  (32'h0000_0000),
        .CNT_WIDTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .PC_Write      (PC_Write),
        .Branch        (Branch),
        .PC_Src        (PC_Src),
        .PC_J          (PC_J),
        .IR_Write      (IR_Write),
        .IorD          (IorD),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .rd_data       (rd_data),
        .mem_addr      (mem_addr),
        .pc            (pc),
        .instr         (instr),
        .Op            (Op),
        .Funct         (Funct),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .imm           (imm),
        .alu_out       (alu_out),
        .mdr           (mdr),
        .fetch_count   (fetch_count),
        .pc_misaligned (pc_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        PC_Write = 1'b0;
        Branch   = 1'b0;
        PC_Src   = 1'b0;
        PC_J     = 1'b0;
        IR_Write = 1'b0;
        IorD     = 1'b0;
        alu_zero = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        idle();
        alu_result = '0;
        rd_data    = '0;

        // reset held two cycles with random strobes
        for (int i = 0; i < 2; i++) begin
            PC_Write   = 1'($urandom);
            Branch     = 1'($urandom);
            PC_Src     = 1'($urandom);
            PC_J       = 1'($urandom);
            IR_Write   = 1'($urandom);
            alu_zero   = 1'($urandom);
            alu_result = $urandom;
            rd_data    = $urandom;
            tick();
        end
        rst = 1'b0;
        idle();
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_op", 32'(Op), 32'h0);
        chk("rst_funct", 32'(Funct), 32'h0);
        chk("rst_cnt", 32'(fetch_count), 32'h0);
        chk("rst_mis", 32'(pc_misaligned), 32'h0);
        chk("rst_alu_out", alu_out, 32'h0);
        chk("rst_mdr", mdr, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);

        // fetch
        rd_data    = 32'h2008_0005;
        alu_result = 32'h0000_0004;
        PC_Write   = 1'b1;
        IR_Write   = 1'b1;
        tick();
        idle();
        chk("f_pc", pc, 32'h4);
        chk("f_op", 32'(Op), 32'h08);
        chk("f_rs", 32'(rs), 32'h0);
        chk("f_rt", 32'(rt), 32'h8);
        chk("f_imm", 32'(imm), 32'h0005);
        chk("f_cnt", 32'(fetch_count), 32'h1);
        chk("f_mdr", mdr, 32'h2008_0005);
        chk("f_addr", mem_addr, 32'h4);

        // BEQ taken: decode captures target, then redirect
        alu_result = 32'h0000_0020;
        tick();
        chk("beq_alu_out", alu_out, 32'h20);
        chk("beq_dec_pc", pc, 32'h4);
        PC_Src     = 1'b1;
        PC_J       = 1'b1;
        Branch     = 1'b1;
        alu_zero   = 1'b1;
        alu_result = 32'h0000_0099;
        tick();
        idle();
        chk("beq_taken", pc, 32'h20);
        chk("beq_addr", mem_addr, 32'h20);

        // BEQ not taken
        alu_result = 32'h0000_0040;
        tick();
        PC_Src     = 1'b1;
        PC_J       = 1'b1;
        Branch     = 1'b1;
        alu_zero   = 1'b0;
        alu_result = 32'h0000_0044;
        tick();
        idle();
        chk("beq_not_taken", pc, 32'h20);

        // Branch and PC_Write together: one load of next_pc
        alu_result = 32'h1000_0004;
        PC_Write   = 1'b1;
        Branch     = 1'b1;
        alu_zero   = 1'b1;
        tick();
        idle();
        chk("bw_pc", pc, 32'h1000_0004);

        // fetch a J instruction
        rd_data    = 32'h0800_0040;
        alu_result = 32'h1000_0008;
        PC_Write   = 1'b1;
        IR_Write   = 1'b1;
        tick();
        idle();
        chk("j_fetch_pc", pc, 32'h1000_0008);
        chk("j_instr", instr, 32'h0800_0040);
        chk("j_op", 32'(Op), 32'h02);
        chk("j_cnt", 32'(fetch_count), 32'h2);

        // jump
        PC_Src     = 1'b1;
        PC_J       = 1'b0;
        PC_Write   = 1'b1;
        alu_result = 32'h0000_0abc;
        tick();
        idle();
        chk("jump_pc", pc, 32'h1000_0100);
        chk("jump_mis", 32'(pc_misaligned), 32'h0);

        // misaligned load, sticky
        PC_Write   = 1'b1;
        alu_result = 32'h0000_0006;
        tick();
        idle();
        chk("mis_pc", pc, 32'h6);
        chk("mis_set", 32'(pc_misaligned), 32'h1);
        PC_Write   = 1'b1;
        alu_result = 32'h0000_0008;
        tick();
        idle();
        chk("mis_pc2", pc, 32'h8);
        chk("mis_sticky", 32'(pc_misaligned), 32'h1);

        // IorD selects alu_out
        alu_result = 32'h0000_0080;
        tick();
        IorD = 1'b1;
        #1;
        chk("iord_addr", mem_addr, 32'h80);
        chk("iord_pc", pc, 32'h8);
        tick();
        chk("iord_pc_hold", pc, 32'h8);
        IorD = 1'b0;
        #1;
        chk("iord_back", mem_addr, 32'h8);

        // reset mid-stream, then counter wrap
        rst = 1'b1;
        PC_Write   = 1'b1;
        IR_Write   = 1'b1;
        alu_result = 32'h0000_0300;
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("rst2_pc", pc, 32'h0);
        chk("rst2_mis", 32'(pc_misaligned), 32'h0);
        chk("rst2_cnt", 32'(fetch_count), 32'h0);
        chk("rst2_addr", mem_addr, 32'h0);
        IR_Write = 1'b1;
        rd_data  = 32'h0000_0000;
        for (int i = 0; i < 16; i++) tick();
        chk("cnt_16", 32'(fetch_count), 32'h0);
        tick();
        IR_Write = 1'b0;
        chk("cnt_17", 32'(fetch_count), 32'h1);
        tick();
        chk("cnt_hold", 32'(fetch_count), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
